// File: rtl/serial_word_tx_if.sv
// Handshake and serial-out bundle for serial_word_tx.
// The master side supplies words; the slave side is the transmitter.
interface serial_word_tx_if #(
  parameter int WIDTH = 6
);
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Ready;
  logic             SO;
  logic             Frame;
  logic             Done;

  modport master (
    output Load,
    output D,
    input  Ready,
    input  SO,
    input  Frame,
    input  Done
  );

  modport slave (
    input  Load,
    input  D,
    output Ready,
    output SO,
    output Frame,
    output Done
  );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter, MSB first, with optional idle gap.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data LSB.
module serial_word_tx #(
  parameter int WIDTH = 6,
  parameter int GAP   = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  serial_word_tx_if.slave   bus
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(L - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(L - 2);
  localparam logic [GW-1:0] GCNT_ZERO  = GW'(0);
  localparam logic [GW-1:0] GCNT_ONE   = GW'(1);
  localparam logic [GW-1:0] GCNT_LAST  = GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  state_t        state_r, state_s;
  logic [L-1:0]  sh_r, sh_s;
  logic [L-1:0]  capture_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [GW-1:0] gcnt_r, gcnt_s;
  logic          ready_r, ready_s;
  logic          frame_r, frame_s;
  logic          done_r, done_s;

`ifdef SERIAL_TX_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Parity rides in the LSB of the shift register so it leaves right after the data.
  assign capture_s = {bus.D, even_parity(bus.D)};
`else
  assign capture_s = bus.D;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    cnt_s   = cnt_r;
    gcnt_s  = gcnt_r;
    ready_s = ready_r;
    frame_s = frame_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Load) begin
          state_s = ST_SHIFT;
          sh_s    = capture_s;
          cnt_s   = CNT_ZERO;
          ready_s = 1'b0;
          frame_s = 1'b1;
        end else begin
          ready_s = 1'b1;
          frame_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Zeros shift in, so the register is empty once the last bit leaves.
        sh_s = {sh_r[L-2:0], 1'b0};
        if (cnt_r == CNT_LAST) begin
          frame_s = 1'b0;
          cnt_s   = CNT_ZERO;
          gcnt_s  = GCNT_ZERO;
          if (GAP > 0) begin
            state_s = ST_GAP;
            ready_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
            ready_s = 1'b1;
          end
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          frame_s = 1'b1;
          ready_s = 1'b0;
          done_s  = (cnt_r == CNT_PENULT);
        end
      end
      ST_GAP: begin
        if (gcnt_r == GCNT_LAST) begin
          state_s = ST_IDLE;
          gcnt_s  = GCNT_ZERO;
          ready_s = 1'b1;
        end else begin
          gcnt_s  = gcnt_r + GCNT_ONE;
          ready_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sh_s    = {L{1'b0}};
        cnt_s   = CNT_ZERO;
        gcnt_s  = GCNT_ZERO;
        ready_s = 1'b1;
        frame_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
      sh_r    <= {L{1'b0}};
      cnt_r   <= CNT_ZERO;
      gcnt_r  <= GCNT_ZERO;
      ready_r <= 1'b1;
      frame_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      cnt_r   <= cnt_s;
      gcnt_r  <= gcnt_s;
      ready_r <= ready_s;
      frame_r <= frame_s;
      done_r  <= done_s;
    end
  end

  assign bus.SO    = sh_r[L-1];
  assign bus.Ready = ready_r;
  assign bus.Frame = frame_r;
  assign bus.Done  = done_r;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed self-checking bench for serial_word_tx (GAP=1 and GAP=0 instances).
// Expected streams follow the build: parity bit appended when SERIAL_TX_PARITY_EN is defined.
module tb_serial_word_tx;
  localparam int W = 6;
`ifdef SERIAL_TX_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  logic Clock;
  logic Resetn;
  int   checks;
  int   errors;

  serial_word_tx_if #(.WIDTH(W)) bus_a ();
  serial_word_tx_if #(.WIDTH(W)) bus_b ();

  serial_word_tx #(.WIDTH(W), .GAP(1)) dut_a (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_a)
  );

  serial_word_tx #(.WIDTH(W), .GAP(0)) dut_b (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Called right after the accept edge; walks the whole frame and scrambles D mid-frame.
  task automatic frame_check(input logic [W-1:0] w, input logic p, input string tag);
    logic exp_so;
    for (int k = 0; k < L; k++) begin
      if (k > 0) tick();
      if (k == 1) bus_a.D = ~w;
      exp_so = (k < W) ? w[W-1-k] : p;
      chk({tag, " so"}, 32'(bus_a.SO), 32'(exp_so));
      chk({tag, " frame"}, 32'(bus_a.Frame), 32'd1);
      chk({tag, " done"}, 32'(bus_a.Done), (k == L - 1) ? 32'd1 : 32'd0);
      chk({tag, " ready"}, 32'(bus_a.Ready), 32'd0);
    end
  endtask

  task automatic gap_and_ready(input string tag);
    tick();
    chk({tag, " gap so"}, 32'(bus_a.SO), 32'd0);
    chk({tag, " gap frame"}, 32'(bus_a.Frame), 32'd0);
    chk({tag, " gap done"}, 32'(bus_a.Done), 32'd0);
    chk({tag, " gap ready"}, 32'(bus_a.Ready), 32'd0);
    tick();
    chk({tag, " ready back"}, 32'(bus_a.Ready), 32'd1);
    chk({tag, " idle frame"}, 32'(bus_a.Frame), 32'd0);
  endtask

  task automatic send_pulse(input logic [W-1:0] w, input logic p, input string tag);
    bus_a.D    = w;
    bus_a.Load = 1'b1;
    tick();
    bus_a.Load = 1'b0;
    frame_check(w, p, tag);
    gap_and_ready(tag);
  endtask

  initial begin
    logic [W-1:0] wb;
    int           m;
    logic         exp_so;
    checks = 0;
    errors = 0;

    // Reset held two edges with Load asserted
    Resetn     = 1'b0;
    bus_a.Load = 1'b1;
    bus_a.D    = 6'b101101;
    bus_b.Load = 1'b0;
    bus_b.D    = 6'b000000;
    tick();
    tick();
    chk("rst ready", 32'(bus_a.Ready), 32'd1);
    chk("rst so", 32'(bus_a.SO), 32'd0);
    chk("rst frame", 32'(bus_a.Frame), 32'd0);
    chk("rst done", 32'(bus_a.Done), 32'd0);
    bus_a.Load = 1'b0;
    Resetn     = 1'b1;
    tick();
    chk("post rst ready", 32'(bus_a.Ready), 32'd1);
    chk("post rst frame", 32'(bus_a.Frame), 32'd0);

    // Basic word and parity vectors
    send_pulse(6'b101101, 1'b0, "basic");
    send_pulse(6'b100000, 1'b1, "par1");

    // Load held high: second accept L+GAP+1 edges after the first
    bus_a.D    = 6'b111000;
    bus_a.Load = 1'b1;
    tick();
    frame_check(6'b111000, 1'b1, "hs1");
    bus_a.D = 6'b000111;
    tick();
    chk("hs gap frame", 32'(bus_a.Frame), 32'd0);
    chk("hs gap ready", 32'(bus_a.Ready), 32'd0);
    tick();
    chk("hs ready", 32'(bus_a.Ready), 32'd1);
    chk("hs ready frame", 32'(bus_a.Frame), 32'd0);
    tick();
    frame_check(6'b000111, 1'b1, "hs2");
    bus_a.Load = 1'b0;
    gap_and_ready("hs2");

    // Reset mid-frame at t0+3
    bus_a.D    = 6'b101101;
    bus_a.Load = 1'b1;
    tick();
    bus_a.Load = 1'b0;
    tick();
    tick();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    chk("midrst frame", 32'(bus_a.Frame), 32'd0);
    chk("midrst so", 32'(bus_a.SO), 32'd0);
    chk("midrst done", 32'(bus_a.Done), 32'd0);
    chk("midrst ready", 32'(bus_a.Ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst after done", 32'(bus_a.Done), 32'd0);
      chk("midrst after frame", 32'(bus_a.Frame), 32'd0);
    end
    send_pulse(6'b100000, 1'b1, "fresh");

    // GAP=0 instance: Load held, one idle clock between frames
    chk("b2b ready", 32'(bus_b.Ready), 32'd1);
    wb         = 6'b111000;
    bus_b.D    = wb;
    bus_b.Load = 1'b1;
    tick();
    for (int n = 0; n < 3 * (L + 1); n++) begin
      if (n > 0) tick();
      m = n % (L + 1);
      if (m < W)      exp_so = wb[W-1-m];
      else if (m < L) exp_so = 1'b1;
      else            exp_so = 1'b0;
      chk("b2b frame", 32'(bus_b.Frame), (m < L) ? 32'd1 : 32'd0);
      chk("b2b so", 32'(bus_b.SO), 32'(exp_so));
      chk("b2b done", 32'(bus_b.Done), (m == L - 1) ? 32'd1 : 32'd0);
      chk("b2b ready", 32'(bus_b.Ready), (m == L) ? 32'd1 : 32'd0);
    end
    bus_b.Load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-in, serial-out transmitter that accepts a parallel word over a load/ready handshake and shifts it out MSB-first, one bit per clock. Its `SO` output drives the `SI` input of the 6-bit serial-in shift-register stage directly downstream. `Frame` marks every clock in which `SO` carries a valid bit, and `Done` marks the last bit of each word.

## Interface
- `WIDTH`, default 6: data bits per word; legal range ≥ 2.
- `GAP`, default 1: idle clocks inserted after each word before `Ready` returns; legal range ≥ 0.
- `Clock`  in  1  rising-edge clock.
- `Resetn`  in  1  synchronous, active-low reset, sampled on the rising edge of `Clock`.
- `Load`  in  1  request to accept `D`; honoured only on an edge where `Ready`=1.
- `D`  in  WIDTH  parallel word; sampled only on the accept edge.
- `Ready`  out  1  high while idle and able to accept a word.
- `SO`  out  1  serial data out, MSB first; connects to downstream `SI`.
- `Frame`  out  1  high for every clock in which `SO` holds a valid bit.
- `Done`  out  1  one-clock pulse coincident with the last bit of a word.

## Operation
- All outputs are registered. The design has one clock domain.
- States:
  - `IDLE`: `Ready`=1, `SO`=0, `Frame`=0, `Done`=0.
  - `SHIFT`: `Frame`=1, `Ready`=0.
  - `GAP`: `SO`=0, `Frame`=0, `Ready`=0.
- `IDLE`→`SHIFT` on an edge with `Load`=1 and `Resetn`=1.
  - Capture `D` into the shift register.
  - Drive `SO` with `D[WIDTH-1]`.
  - Clear the bit counter.
- In `SHIFT`, each edge shifts left by one and increments the counter.
  - Frame length `L` = `WIDTH`, or `WIDTH+1` when parity is compiled in.
  - After the last bit: go to `GAP` if `GAP`>0, otherwise go to `IDLE`.
- `GAP` holds for exactly `GAP` clocks, then returns to `IDLE`.
- `Load` is ignored whenever `Ready`=0. Changes on `D` after the accept edge have no effect on the word in flight.
- The counter is sized to `$clog2(WIDTH+2)` bits and never wraps within a frame.
- Reset (`Resetn`=0 on any edge, including mid-frame):
  - The state machine goes to `IDLE`.
  - The shift register and counter clear to 0.
  - Outputs take `Ready`=1, `SO`=0, `Frame`=0, `Done`=0.
  - An aborted frame produces no `Done`.
  - `Load` is ignored on that same edge.

## Timing
- Let t0 be the accept edge.
- Bit k (k = 0..`WIDTH`-1), i.e. `D[WIDTH-1-k]`, is on `SO` in the clock following edge t0+k.
- `Frame` is high after edges t0 .. t0+L-1.
- `Done` is high only in the clock following edge t0+L-1.
- `GAP` occupies the clocks following edges t0+L .. t0+L+GAP-1.
- `Ready` rises after edge t0+L+GAP. The earliest next accept is edge t0+L+GAP+1, so the word period is L+GAP+1 clocks.
- Latency from the accept edge to the first valid bit is 0 clocks: the bit is present immediately after t0.
- Downstream stage: sample `SI` on the same edge. After L edges with `Frame`=1 it holds the complete word, MSB in the highest position.

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - One even-parity bit, equal to `^D` of the captured word, is appended after the data LSB.
  - L = `WIDTH+1`. `Frame` covers the parity bit, and `Done` coincides with the parity bit.
- `SERIAL_TX_PARITY_EN` undefined:
  - No parity logic is built. L = `WIDTH`, and `Done` coincides with the data LSB.

## Test plan
- **Reset:** hold `Resetn`=0 for 2 edges with `Load`=1 → `Ready`=1, `SO`=0, `Frame`=0, `Done`=0; no word accepted.
- **Basic word** (`WIDTH`=6, `GAP`=1, no parity): `D`=6'b101101, `Load` pulsed at t0 → `SO`=1,0,1,1,0,1 over 6 clocks with `Frame`=1; `Done` on the 6th clock; `SO`=0 during the gap; `Ready` high after t0+7.
- **Parity build:** `D`=6'b101101 → 7th bit 0; `D`=6'b100000 → 7th bit 1; `Done` on the 7th bit in both cases.
- **Handshake:** hold `Load`=1 continuously, `D`=6'b111000 then 6'b000111 → accepts at t0 and t0+8; second `SO` stream is 0,0,0,1,1,1; `D` changes mid-frame do not alter the output.
- **Back-to-back** (`GAP`=0): `Load` held high → words accepted every 7 clocks; exactly one `SO`=0/`Frame`=0 idle clock between frames.
- **Reset mid-frame:** drive `Resetn`=0 at edge t0+3 → `Frame`, `SO`, `Done` are 0 and `Ready`=1 after that edge; no `Done` pulse; the next `Load` transmits a fresh, full word.
